// File: rtl/blackjack_pkg.sv
// Shared encodings, widths and helpers for the blackjack round controller.
package blackjack_pkg;

    localparam int CARD_W = 4;
    localparam int SUM_W  = 5;
    localparam int CNT_W  = 3;
    localparam int BET_W  = 5;

    localparam logic [SUM_W-1:0] BUST_LIMIT = 5'd21;
    localparam logic [SUM_W-1:0] ACE_BONUS  = 5'd10;
    // Highest raw total at which an ace can still count as 11.
    localparam logic [SUM_W-1:0] SOFT_LIMIT = BUST_LIMIT - ACE_BONUS;

    typedef enum logic [2:0] {
        PH_BET    = 3'd0,
        PH_DEAL   = 3'd1,
        PH_SHOW   = 3'd2,
        PH_PLAYER = 3'd3,
        PH_DEALER = 3'd4,
        PH_REVEAL = 3'd5,
        PH_RESULT = 3'd6
    } phase_e;

    typedef enum logic [1:0] {
        OUT_WIN  = 2'd0,
        OUT_LOSE = 2'd1,
        OUT_DRAW = 2'd2
    } outcome_e;

    // Card codes outside 1..10 (0, 11..15) count as a ten-value card.
    function automatic logic [CARD_W-1:0] card_norm(input logic [CARD_W-1:0] v);
        return (v >= 4'd1 && v <= 4'd10) ? v : 4'd10;
    endfunction

endpackage

// File: rtl/hand_accum.sv
// One hand: running raw total, ace-seen flag, soft/hard effective total and
// a saturating card count.
module hand_accum
    import blackjack_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              clear,
    input  logic              add,
    input  logic [CARD_W-1:0] val,
    output logic [SUM_W-1:0]  raw,
    output logic              ace,
    output logic [SUM_W-1:0]  eff,
    output logic [CNT_W-1:0]  cnt
);

    // Accumulate a card on each add pulse; clear wins over add.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            raw <= '0;
            ace <= 1'b0;
            cnt <= '0;
        end else if (clear) begin
            raw <= '0;
            ace <= 1'b0;
            cnt <= '0;
        end else if (add) begin
            raw <= raw + SUM_W'(card_norm(val));
            ace <= ace | (val == 4'd1);
            if (cnt != '1)
                cnt <= cnt + 1'b1;
        end
    end

    // One ace counts as 11 whenever that does not push the hand over 21.
    always_comb begin
        eff = (ace && raw <= SOFT_LIMIT) ? raw + ACE_BONUS : raw;
    end

endmodule

// File: rtl/blackjack_phase_ctrl.sv
// Round sequencer: bet, deal, show, player turn, dealer draw, reveal, result.
// Owns the coin balance, both hands and the card request handshake.
module blackjack_phase_ctrl
    import blackjack_pkg::*;
#(
    parameter int START_COINS  = 20,
    parameter int COIN_W       = 8,
    parameter int DEALER_STAND = 17
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              next_p,
    input  logic              hit_p,
    input  logic              stand_p,
    input  logic              double_p,
    input  logic [3:0]        bet,
    output logic              card_req,
    input  logic              card_valid,
    input  logic [3:0]        card_val,
    output logic [2:0]        phase,
    output logic [4:0]        player_sum,
    output logic [4:0]        dealer_sum,
    output logic [3:0]        dealer_shown,
    output logic [COIN_W-1:0] coins,
    output logic [4:0]        bet_amt,
    output logic              led_win,
    output logic              led_lose,
    output logic              led_draw
);

    // Wide enough for coins+bet and for 2*bet (up to 30).
    localparam int WIDE = (COIN_W > 6) ? COIN_W + 1 : 7;
    localparam logic [COIN_W-1:0] COIN_MAX = '1;

    phase_e              state, state_nxt;
    outcome_e            outcome;
    logic                card_req_nxt, doubled, doubled_nxt, hand_clr;
    logic [COIN_W-1:0]   coins_nxt;
    logic [BET_W-1:0]    bet_nxt;
    logic [CARD_W-1:0]   shown_nxt;
    logic                win_nxt, lose_nxt, draw_nxt;
    logic                consume, to_player, to_dealer;
    logic [SUM_W-1:0]    p_raw, p_eff, d_raw, d_eff;
    logic                p_ace, d_ace;
    logic [CNT_W-1:0]    p_cnt, d_cnt;
    logic [WIDE-1:0]     coins_w, win_sum;

    assign consume   = card_req & card_valid;
    // During the deal, cards alternate player/dealer starting with the player.
    assign to_player = consume & ((state == PH_PLAYER) | ((state == PH_DEAL) & (p_cnt == d_cnt)));
    assign to_dealer = consume & ((state == PH_DEALER) | ((state == PH_DEAL) & (p_cnt != d_cnt)));

    assign coins_w = WIDE'(coins);
    assign win_sum = coins_w + WIDE'(bet_amt);

    hand_accum u_player (
        .clk(clk), .reset(reset), .clear(hand_clr), .add(to_player), .val(card_val),
        .raw(p_raw), .ace(p_ace), .eff(p_eff), .cnt(p_cnt)
    );

    hand_accum u_dealer (
        .clk(clk), .reset(reset), .clear(hand_clr), .add(to_dealer), .val(card_val),
        .raw(d_raw), .ace(d_ace), .eff(d_eff), .cnt(d_cnt)
    );

    // A hand over 21 always has eff == raw, so bust is detected on raw.
    always_comb begin
        if (p_raw > BUST_LIMIT)
            outcome = OUT_LOSE;
        else if (d_raw > BUST_LIMIT)
            outcome = OUT_WIN;
        else if (p_eff > d_eff)
            outcome = OUT_WIN;
        else if (p_eff < d_eff)
            outcome = OUT_LOSE;
        else
            outcome = OUT_DRAW;
    end

    // Next-state and datapath updates; buttons are ignored while a card is pending.
    always_comb begin
        state_nxt    = state;
        card_req_nxt = card_req;
        coins_nxt    = coins;
        bet_nxt      = bet_amt;
        shown_nxt    = dealer_shown;
        doubled_nxt  = doubled;
        win_nxt      = led_win;
        lose_nxt     = led_lose;
        draw_nxt     = led_draw;
        hand_clr     = 1'b0;
        case (state)
            PH_BET: begin
                if (next_p && bet != 4'd0 && WIDE'(bet) <= coins_w) begin
                    bet_nxt      = {1'b0, bet};
                    hand_clr     = 1'b1;
                    shown_nxt    = '0;
                    doubled_nxt  = 1'b0;
                    card_req_nxt = 1'b1;
                    state_nxt    = PH_DEAL;
                end
            end
            PH_DEAL: begin
                if (card_req) begin
                    if (to_dealer && d_cnt == 3'd0)
                        shown_nxt = card_norm(card_val);
                    // Second dealer card is the fourth and last of the deal.
                    if (to_dealer && d_cnt == 3'd1)
                        card_req_nxt = 1'b0;
                end else if (d_cnt == 3'd2) begin
                    state_nxt = PH_SHOW;
                end
            end
            PH_SHOW: begin
                if (next_p)
                    state_nxt = PH_PLAYER;
            end
            PH_PLAYER: begin
                if (card_req) begin
                    if (consume)
                        card_req_nxt = 1'b0;
                end else if (p_raw > BUST_LIMIT) begin
                    state_nxt = PH_REVEAL;
                end else if (doubled) begin
                    state_nxt = PH_DEALER;
                end else if (stand_p) begin
                    state_nxt = PH_DEALER;
                end else if (double_p && p_cnt == 3'd2 && WIDE'({bet_amt, 1'b0}) <= coins_w) begin
                    bet_nxt      = {bet_amt[3:0], 1'b0};
                    doubled_nxt  = 1'b1;
                    card_req_nxt = 1'b1;
                end else if (hit_p) begin
                    card_req_nxt = 1'b1;
                end
            end
            PH_DEALER: begin
                if (card_req) begin
                    if (consume)
                        card_req_nxt = 1'b0;
                end else if (d_eff < SUM_W'(DEALER_STAND)) begin
                    card_req_nxt = 1'b1;
                end else begin
                    state_nxt = PH_REVEAL;
                end
            end
            PH_REVEAL: begin
                if (next_p) begin
                    state_nxt = PH_RESULT;
                    win_nxt   = (outcome == OUT_WIN);
                    lose_nxt  = (outcome == OUT_LOSE);
                    draw_nxt  = (outcome == OUT_DRAW);
                    case (outcome)
                        OUT_WIN:  coins_nxt = (win_sum > WIDE'(COIN_MAX)) ? COIN_MAX : win_sum[COIN_W-1:0];
                        OUT_LOSE: coins_nxt = coins - COIN_W'(bet_amt);
                        default:  coins_nxt = coins;
                    endcase
                end
            end
            PH_RESULT: begin
                if (next_p) begin
                    state_nxt = PH_BET;
                    win_nxt   = 1'b0;
                    lose_nxt  = 1'b0;
                    draw_nxt  = 1'b0;
                end
            end
            default: state_nxt = PH_BET;
        endcase
    end

    // Round state and registered outputs; reset aborts any pending card request.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state        <= PH_BET;
            card_req     <= 1'b0;
            coins        <= COIN_W'(START_COINS);
            bet_amt      <= '0;
            dealer_shown <= '0;
            doubled      <= 1'b0;
            led_win      <= 1'b0;
            led_lose     <= 1'b0;
            led_draw     <= 1'b0;
        end else begin
            state        <= state_nxt;
            card_req     <= card_req_nxt;
            coins        <= coins_nxt;
            bet_amt      <= bet_nxt;
            dealer_shown <= shown_nxt;
            doubled      <= doubled_nxt;
            led_win      <= win_nxt;
            led_lose     <= lose_nxt;
            led_draw     <= draw_nxt;
        end
    end

    // An ace in hand means the effective total is at least 11.
    a_player_soft: assert property (@(posedge clk) disable iff (!reset) p_ace |-> p_eff >= 5'd11);
    a_dealer_soft: assert property (@(posedge clk) disable iff (!reset) d_ace |-> d_eff >= 5'd11);

    assign phase      = state;
    assign player_sum = p_eff;
    assign dealer_sum = d_eff;

endmodule

// File: tb/tb_blackjack_phase_ctrl.sv
// Scoreboard bench: each round pushes its expected outcome LEDs and balance,
// compared when the controller enters RESULT; the card source is a queue.
module tb_blackjack_phase_ctrl;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       next_p = 1'b0, hit_p = 1'b0, stand_p = 1'b0, double_p = 1'b0;
    logic [3:0] bet = 4'd0;
    logic       card_req;
    logic       card_valid = 1'b0;
    logic [3:0] card_val = 4'd0;
    logic [2:0] phase;
    logic [4:0] player_sum, dealer_sum;
    logic [3:0] dealer_shown;
    logic [7:0] coins;
    logic [4:0] bet_amt;
    logic       led_win, led_lose, led_draw;

    blackjack_phase_ctrl #(.START_COINS(20), .COIN_W(8), .DEALER_STAND(17)) dut (
        .clk(clk), .reset(reset),
        .next_p(next_p), .hit_p(hit_p), .stand_p(stand_p), .double_p(double_p),
        .bet(bet), .card_req(card_req), .card_valid(card_valid), .card_val(card_val),
        .phase(phase), .player_sum(player_sum), .dealer_sum(dealer_sum),
        .dealer_shown(dealer_shown), .coins(coins), .bet_amt(bet_amt),
        .led_win(led_win), .led_lose(led_lose), .led_draw(led_draw)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Card source: valid whenever a card is queued; popped on a consume edge.
    int card_q[$];
    int cards_taken = 0;
    int popped;
    always @(posedge clk) begin
        if (card_req && card_valid && card_q.size() > 0) begin
            popped = card_q.pop_front();
            cards_taken++;
        end
    end
    always @(negedge clk) begin
        card_valid = card_q.size() > 0;
        card_val   = (card_q.size() > 0) ? 4'(card_q[0]) : 4'd0;
    end

    // Expected round results: leds as {win,lose,draw} and final balance.
    typedef struct {
        logic [2:0] leds;
        logic [7:0] coins;
    } exp_t;
    exp_t exp_q[$];
    exp_t exp_cur;
    logic [2:0] prev_phase = 3'd0;

    always @(negedge clk) begin
        if (reset && phase == 3'd6) begin
            checks++;
            if ($countones({led_win, led_lose, led_draw}) != 1) begin
                errors++;
                $display("FAIL result_onehot: leds=%b want exactly one set", {led_win, led_lose, led_draw});
            end
            if (prev_phase != 3'd6) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL result_unexpected: RESULT entered with no expected round queued");
                end else begin
                    exp_cur = exp_q.pop_front();
                    if ({led_win, led_lose, led_draw} !== exp_cur.leds || coins !== exp_cur.coins) begin
                        errors++;
                        $display("FAIL result_scoreboard: leds=%b coins=%0d want leds=%b coins=%0d",
                                 {led_win, led_lose, led_draw}, coins, exp_cur.leds, exp_cur.coins);
                    end
                end
            end
        end
        prev_phase = phase;
    end

    // One-cycle button pulse; which: 0 next, 1 hit, 2 stand, 3 double, 4 stand+hit.
    task automatic press(input int which);
        @(negedge clk);
        next_p   = (which == 0);
        hit_p    = (which == 1) || (which == 4);
        stand_p  = (which == 2) || (which == 4);
        double_p = (which == 3);
        @(negedge clk);
        next_p = 1'b0; hit_p = 1'b0; stand_p = 1'b0; double_p = 1'b0;
    endtask

    // Bounded wait for a phase; an expired budget counts as a failure.
    task automatic wait_phase(input logic [2:0] p, input int budget, input string tag);
        int n = 0;
        while (phase !== p && n < budget) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (phase !== p) begin
            errors++;
            $display("FAIL %s: phase=%0d want %0d within %0d cycles", tag, phase, p, budget);
        end
    endtask

    // Bet, queue the four deal cards (P,D,P,D) and run to SHOW.
    task automatic deal_round(input logic [3:0] b, input int c0, input int c1, input int c2, input int c3);
        card_q.push_back(c0); card_q.push_back(c1); card_q.push_back(c2); card_q.push_back(c3);
        bet = b;
        press(0);
        wait_phase(3'd2, 20, "deal_to_show");
    endtask

    // REVEAL -> RESULT -> BET, LEDs cleared on return to BET.
    task automatic finish_round(input string tag);
        press(0);
        checks++;
        if (phase !== 3'd6) begin
            errors++;
            $display("FAIL %s_result_phase: phase=%0d want 6", tag, phase);
        end
        press(0);
        checks++;
        if (phase !== 3'd0 || {led_win, led_lose, led_draw} !== 3'b000) begin
            errors++;
            $display("FAIL %s_back_to_bet: phase=%0d leds=%b want phase 0 leds 000", tag, phase, {led_win, led_lose, led_draw});
        end
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        checks++;
        if (phase !== 3'd0 || coins !== 8'd20 || bet_amt !== 5'd0 || card_req !== 1'b0 ||
            player_sum !== 5'd0 || dealer_sum !== 5'd0 || dealer_shown !== 4'd0 ||
            {led_win, led_lose, led_draw} !== 3'b000) begin
            errors++;
            $display("FAIL reset_values: phase=%0d coins=%0d bet_amt=%0d req=%b ps=%0d ds=%0d shown=%0d leds=%b",
                     phase, coins, bet_amt, card_req, player_sum, dealer_sum, dealer_shown, {led_win, led_lose, led_draw});
        end
        reset = 1'b1;
        @(negedge clk);
        checks++;
        if (phase !== 3'd0 || coins !== 8'd20 || card_req !== 1'b0) begin
            errors++;
            $display("FAIL reset_release: phase=%0d coins=%0d req=%b want 0/20/0", phase, coins, card_req);
        end
    endtask

    // bet 6: player 10,7 vs dealer 5,6 + 8 -> 19; player loses, 20 -> 14.
    task automatic test_basic_round();
        card_q.push_back(10); card_q.push_back(5); card_q.push_back(7); card_q.push_back(6);
        exp_q.push_back('{leds: 3'b010, coins: 8'd14});
        bet = 4'd6;
        press(0);
        checks++;
        if (phase !== 3'd1 || card_req !== 1'b1 || bet_amt !== 5'd6) begin
            errors++;
            $display("FAIL basic_deal_entry: phase=%0d req=%b bet_amt=%0d want 1/1/6", phase, card_req, bet_amt);
        end
        repeat (4) @(negedge clk);
        checks++;
        if (phase !== 3'd1 || card_req !== 1'b0 || player_sum !== 5'd17 || dealer_sum !== 5'd11) begin
            errors++;
            $display("FAIL basic_deal_cards: phase=%0d req=%b ps=%0d ds=%0d want 1/0/17/11", phase, card_req, player_sum, dealer_sum);
        end
        @(negedge clk);
        checks++;
        if (phase !== 3'd2 || dealer_shown !== 4'd5) begin
            errors++;
            $display("FAIL basic_show: phase=%0d shown=%0d want 2/5", phase, dealer_shown);
        end
        card_q.push_back(8);
        press(0);
        checks++;
        if (phase !== 3'd3) begin
            errors++;
            $display("FAIL basic_player: phase=%0d want 3", phase);
        end
        press(2);
        checks++;
        if (phase !== 3'd4) begin
            errors++;
            $display("FAIL basic_stand: phase=%0d want 4", phase);
        end
        wait_phase(3'd5, 20, "basic_reveal");
        checks++;
        if (dealer_sum !== 5'd19 || cards_taken !== 5) begin
            errors++;
            $display("FAIL basic_dealer_draw: ds=%0d cards=%0d want 19/5", dealer_sum, cards_taken);
        end
        finish_round("basic");
    endtask

    // coins 14: zero bet and a bet above the balance are both refused.
    task automatic test_bad_bet();
        bet = 4'd0;
        press(0);
        @(negedge clk);
        checks++;
        if (phase !== 3'd0 || card_req !== 1'b0) begin
            errors++;
            $display("FAIL bad_bet_zero: phase=%0d req=%b want 0/0", phase, card_req);
        end
        bet = 4'd15;
        press(0);
        @(negedge clk);
        checks++;
        if (phase !== 3'd0 || card_req !== 1'b0 || coins !== 8'd14) begin
            errors++;
            $display("FAIL bad_bet_over: phase=%0d req=%b coins=%0d want 0/0/14", phase, card_req, coins);
        end
    endtask

    // bet 2: player A,6 (soft 17) hits 10 -> hard 17, hits 9 -> 26 bust; dealer 12 never draws.
    task automatic test_soft_bust();
        int taken0;
        exp_q.push_back('{leds: 3'b010, coins: 8'd12});
        deal_round(4'd2, 1, 10, 6, 2);
        checks++;
        if (player_sum !== 5'd17 || dealer_sum !== 5'd12) begin
            errors++;
            $display("FAIL soft_deal: ps=%0d ds=%0d want 17/12", player_sum, dealer_sum);
        end
        press(0);
        card_q.push_back(10);
        press(1);
        repeat (3) @(negedge clk);
        checks++;
        if (phase !== 3'd3 || player_sum !== 5'd17) begin
            errors++;
            $display("FAIL soft_hit_hard17: phase=%0d ps=%0d want 3/17", phase, player_sum);
        end
        taken0 = cards_taken;
        card_q.push_back(9);
        press(1);
        wait_phase(3'd5, 20, "soft_bust_reveal");
        checks++;
        if (player_sum !== 5'd26 || dealer_sum !== 5'd12 || cards_taken !== taken0 + 1) begin
            errors++;
            $display("FAIL soft_bust_totals: ps=%0d ds=%0d drawn=%0d want 26/12/1", player_sum, dealer_sum, cards_taken - taken0);
        end
        finish_round("soft_bust");
    endtask

    // coins 12, bet 6: player 5,6 doubles to 12, draws 10 -> 21; dealer 20 stands; 12+12=24.
    task automatic test_double();
        exp_q.push_back('{leds: 3'b100, coins: 8'd24});
        deal_round(4'd6, 5, 10, 6, 10);
        press(0);
        card_q.push_back(10);
        press(3);
        checks++;
        if (bet_amt !== 5'd12 || card_req !== 1'b1) begin
            errors++;
            $display("FAIL double_accept: bet_amt=%0d req=%b want 12/1", bet_amt, card_req);
        end
        wait_phase(3'd5, 20, "double_reveal");
        checks++;
        if (player_sum !== 5'd21 || dealer_sum !== 5'd20) begin
            errors++;
            $display("FAIL double_totals: ps=%0d ds=%0d want 21/20", player_sum, dealer_sum);
        end
        finish_round("double");
    endtask

    // 17 vs 17 push; stand+hit together must stand without drawing the spare card.
    task automatic test_draw_priority();
        int taken0;
        exp_q.push_back('{leds: 3'b001, coins: 8'd24});
        deal_round(4'd3, 10, 10, 7, 7);
        press(0);
        card_q.push_back(5);
        taken0 = cards_taken;
        press(4);
        checks++;
        if (phase !== 3'd4) begin
            errors++;
            $display("FAIL priority_stand: phase=%0d want 4", phase);
        end
        wait_phase(3'd5, 20, "draw_reveal");
        checks++;
        if (cards_taken !== taken0 || card_q.size() !== 1 || player_sum !== 5'd17 || dealer_sum !== 5'd17) begin
            errors++;
            $display("FAIL priority_no_card: drawn=%0d ps=%0d ds=%0d want 0/17/17", cards_taken - taken0, player_sum, dealer_sum);
        end
        finish_round("draw");
        card_q.delete();
    endtask

    // Reset during the deal drops card_req at once and restores the balance.
    task automatic test_reset_mid_deal();
        card_q.push_back(3); card_q.push_back(3); card_q.push_back(3); card_q.push_back(3);
        bet = 4'd4;
        press(0);
        checks++;
        if (card_req !== 1'b1 || phase !== 3'd1) begin
            errors++;
            $display("FAIL mid_deal_started: req=%b phase=%0d want 1/1", card_req, phase);
        end
        @(negedge clk);
        #2 reset = 1'b0;
        #1;
        checks++;
        if (card_req !== 1'b0 || phase !== 3'd0 || coins !== 8'd20 || player_sum !== 5'd0) begin
            errors++;
            $display("FAIL mid_deal_reset: req=%b phase=%0d coins=%0d ps=%0d want 0/0/20/0", card_req, phase, coins, player_sum);
        end
        @(negedge clk);
        reset = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if (card_req !== 1'b0 || phase !== 3'd0 || player_sum !== 5'd0 || dealer_sum !== 5'd0 || card_q.size() !== 3) begin
            errors++;
            $display("FAIL post_reset_ignore: req=%b phase=%0d ps=%0d ds=%0d left=%0d want 0/0/0/0/3",
                     card_req, phase, player_sum, dealer_sum, card_q.size());
        end
        card_q.delete();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_basic_round();
        test_bad_bet();
        test_soft_bust();
        test_double();
        test_draw_priority();
        test_reset_mid_deal();
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: %0d expected rounds never reached RESULT", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/blackjack_phase_ctrl.md
# blackjack_phase_ctrl

Game-sequencing controller for the blackjack FPGA design: owns the round state machine (bet, deal, dealer card show, player turn, dealer draw, reveal, result). It also owns the coin balance and both hands. It requests cards from the card source over a req/valid handshake and presents phase, totals, balance and outcome flags to the seven-segment/LED display logic inside segment_display. Button inputs arrive already debounced and edge-detected.

## Interface
- START_COINS, 20: balance loaded at reset.
- COIN_W, 8: balance width.
- DEALER_STAND, 17: dealer stops drawing at effective total ≥ this.
- clk  in  1  system clock, all logic on rising edge.
- reset  in  1  asynchronous, active-low reset.
- next_p, hit_p, stand_p, double_p  in  1 each  single-cycle button pulses.
- bet  in  4  {bet_8,bet_4,bet_2,bet_1} switch levels, value 0..15.
- card_req  out  1  card request, registered.
- card_valid  in  1  card available this cycle.
- card_val  in  4  card value 1..10, 1 = ace; other codes treated as 10.
- phase  out  3  current state encoding.
- player_sum, dealer_sum  out  5 each  effective hand totals.
- dealer_shown  out  4  dealer first card value.
- coins  out  COIN_W  balance.
- bet_amt  out  5  active wager; doubling makes it up to 30.
- led_win, led_lose, led_draw  out  1 each  round outcome flags.

## Operation
- States and phase codes: BET=0, DEAL=1, SHOW=2, PLAYER=3, DEALER=4, REVEAL=5, RESULT=6.
- BET:
  - next_p with 1 ≤ bet ≤ coins latches bet_amt=bet, clears both hands and goes to DEAL.
  - Otherwise next_p is ignored. With coins=0 the controller stays in BET (game over).
- DEAL: draws 4 cards in order player, dealer, player, dealer, then goes to SHOW.
- SHOW: dealer_shown is valid. next_p goes to PLAYER.
- PLAYER:
  - hit_p draws 1 card.
  - stand_p goes to DEALER.
  - double_p is honoured only with exactly 2 player cards and coins ≥ 2·bet_amt. It doubles bet_amt, draws 1 card, then goes to DEALER.
  - Player effective total > 21 after any draw goes to REVEAL, skipping dealer draws.
- DEALER: draws while dealer effective total < DEALER_STAND, then goes to REVEAL.
- REVEAL: dealer_sum is fully valid. next_p goes to RESULT.
- RESULT outcome:
  - Player bust means lose.
  - Otherwise dealer bust means win.
  - Otherwise the higher total wins and equal totals draw.
- RESULT balance update: win adds bet_amt (saturating at 2^COIN_W−1), lose subtracts bet_amt, draw leaves coins unchanged.
- RESULT: next_p goes to BET.
- Hand arithmetic:
  - raw = sum of card values, 5-bit.
  - ace flag is set if any ace was drawn.
  - effective = raw+10 if ace flag and raw ≤ 11, else raw.
  - Raw total never exceeds 31: player max 21+10, dealer max 16+10.
- Simultaneous pulses in PLAYER: priority stand > double > hit.
- All button pulses are ignored while card_req is high, and in states that do not use them.

## Timing
- Reset values:
  - phase=BET, coins=START_COINS, bet_amt=0.
  - sums=0, dealer_shown=0, card_req=0.
  - All LEDs 0.
- Reset asserted mid-round aborts the handshake: card_req drops asynchronously. A card_valid arriving after reset is ignored.
- Handshake:
  - card_req rises the cycle after the draw decision.
  - A card is consumed on each rising edge with card_req&card_valid.
  - card_req may stay high across back-to-back draws. It falls in the cycle following the last needed card.
  - card_valid without card_req is ignored.
- Sums and the ace flag update on the consume edge. The next draw decision uses the updated total in the following cycle.
- next_p in BET: phase=DEAL and card_req=1 on the next cycle.
- With card_valid held high: the 4th card is consumed 4 cycles after DEAL entry, and phase=SHOW follows 1 cycle later.
- The outcome LEDs and coins update on the same edge that phase becomes RESULT.
- LEDs are cleared on the edge entering BET. Exactly one LED is high throughout RESULT.

## Structure
- blackjack_pkg holds:
  - phase encodings.
  - BUST_LIMIT=21 and ACE_BONUS=10.
  - card and sum widths.
  - outcome enum (WIN/LOSE/DRAW).
- Sub-module hand_accum is instantiated twice, once for the player and once for the dealer.
  - Inputs: clk, reset, clear, add, val.
  - Outputs: raw sum, ace flag, effective total, card count (3-bit, saturating).

## Test plan
- Reset then bet=6, next; cards 10,5,7,6; next; stand; next → phase SHOW then PLAYER then DEALER. Dealer draws once more on effective 11; card 8 gives dealer 19. Player 17 loses: led_lose=1, coins 20→14.
- bet=0 or bet=21-equivalent >coins, next_p → phase stays BET, card_req stays 0.
- Player cards 1,6 (soft 17), hit 10 → player_sum 17, not bust. Hit 9 → 26 bust, phase REVEAL, no dealer draws. RESULT gives led_lose.
- Double with coins=20, bet=6 after cards 5,6 → bet_amt=12, one draw of 10 (21), auto DEALER. Dealer stands on 20 → win, coins=32.
- Dealer 10,7 vs player 10,7 → led_draw=1, coins unchanged. Next → BET, all LEDs 0.
- Assert reset while card_req=1 mid-DEAL with card_valid held → card_req=0 immediately, phase BET, coins=20. Hold stand_p+hit_p together in PLAYER → stand wins, no card drawn.
